// File: rtl/order_ptr_ctrl.sv
// order_ptr_ctrl: four-pointer sequencer for a circular transaction buffer.
// An entry moves through allocate (head), issue (neck), acknowledge (torso)
// and retire (tail). Each stage may advance only onto an entry that the stage
// ahead of it has already released. One slot is always kept empty, so that
// head == tail means the buffer is empty.
module order_ptr_ctrl #(
    parameter int LGFIFO = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_issue,
    input  logic              i_ack,
    input  logic              i_pop,
    output logic [LGFIFO-1:0] o_head,
    output logic [LGFIFO-1:0] o_neck,
    output logic [LGFIFO-1:0] o_torso,
    output logic [LGFIFO-1:0] o_tail,
    output logic              o_push_ok,
    output logic              o_issue_ok,
    output logic              o_ack_ok,
    output logic              o_pop_ok,
    output logic [LGFIFO-1:0] o_fill,
    output logic [LGFIFO-1:0] o_inflight,
    output logic              o_err
);

    localparam logic [LGFIFO-1:0] PTR_ONE  = {{(LGFIFO-1){1'b0}}, 1'b1};
    localparam logic [LGFIFO-1:0] PTR_ZERO = '0;

    logic [LGFIFO-1:0] head_q,  head_d;
    logic [LGFIFO-1:0] neck_q,  neck_d;
    logic [LGFIFO-1:0] torso_q, torso_d;
    logic [LGFIFO-1:0] tail_q,  tail_d;
    logic              err_q,   err_d;

    logic push_ok, issue_ok, ack_ok, pop_ok;
    logic push_go, issue_go, ack_go, pop_go;
    logic rejected;

    // Grants and status come straight from the registered pointers, so a
    // request sees only pre-edge state (no same-cycle bypass between stages).
    always_comb begin
        push_ok  = (head_q + PTR_ONE) != tail_q;
        issue_ok = neck_q  != head_q;
        ack_ok   = torso_q != neck_q;
        pop_ok   = tail_q  != torso_q;

        push_go  = i_push  && push_ok;
        issue_go = i_issue && issue_ok;
        ack_go   = i_ack   && ack_ok;
        pop_go   = i_pop   && pop_ok;

        rejected = (i_push  && !push_ok)  ||
                   (i_issue && !issue_ok) ||
                   (i_ack   && !ack_ok)   ||
                   (i_pop   && !pop_ok);
    end

    // Next-state: flush wins over every advance; otherwise each pointer
    // steps by one when granted and the error flag accumulates rejections.
    always_comb begin
        head_d  = head_q;
        neck_d  = neck_q;
        torso_d = torso_q;
        tail_d  = tail_q;
        err_d   = err_q;

        if (i_clear) begin
            head_d  = PTR_ZERO;
            neck_d  = PTR_ZERO;
            torso_d = PTR_ZERO;
            tail_d  = PTR_ZERO;
            err_d   = 1'b0;
        end else begin
            if (push_go)  head_d  = head_q  + PTR_ONE;
            if (issue_go) neck_d  = neck_q  + PTR_ONE;
            if (ack_go)   torso_d = torso_q + PTR_ONE;
            if (pop_go)   tail_d  = tail_q  + PTR_ONE;
            if (rejected) err_d   = 1'b1;
        end
    end

    // Pointer and error registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q  <= PTR_ZERO;
            neck_q  <= PTR_ZERO;
            torso_q <= PTR_ZERO;
            tail_q  <= PTR_ZERO;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            neck_q  <= neck_d;
            torso_q <= torso_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

    // Output mapping; differences wrap modulo the buffer depth.
    always_comb begin
        o_head     = head_q;
        o_neck     = neck_q;
        o_torso    = torso_q;
        o_tail     = tail_q;
        o_push_ok  = push_ok;
        o_issue_ok = issue_ok;
        o_ack_ok   = ack_ok;
        o_pop_ok   = pop_ok;
        o_fill     = head_q - tail_q;
        o_inflight = neck_q - torso_q;
        o_err      = err_q;
    end

endmodule
